// File: rtl/fb_pattern_gen.sv
// rtl/fb_pattern_gen.sv - paced test-pattern source for the framebuffer write port.
// Define FB_BORDER_EN to force a one-pixel all-ones border around every frame.
module fb_pattern_gen #(
  parameter int WIDTH            = 640,
  parameter int HEIGHT           = 480,
  parameter int COLOR_BITS       = 18,
  parameter int CYCLES_PER_PIXEL = 4,
  parameter int BLOCK            = 32,
  parameter int BLOCK_STEP       = 8,
  parameter int PATTERN_FRAMES   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_mode,
  input  logic                  stall,
  output logic                  fb_vsync,
  output logic                  fb_we,
  output logic [COLOR_BITS-1:0] fb_data,
  output logic [15:0]           frame_cnt,
  output logic                  busy
);

  localparam int C = COLOR_BITS / 3;

  typedef enum logic [1:0] {IDLE, SYNC, PIXEL} state_t;

  state_t          state_q, state_d;
  logic [15:0]     x_q, x_d, y_q, y_d, pace_q, pace_d;
  logic [15:0]     bx_q, bx_d, by_q, by_d;
  logic [15:0]     frame_q, frame_d, acnt_q, acnt_d;
  logic [1:0]      aidx_q, aidx_d, pat_q, pat_d;
  logic [C-1:0]    bgr_q, bgr_d, bgg_q, bgg_d, bgb_q, bgb_d;
  logic [C-1:0]    pr, pg, pb;
  logic [COLOR_BITS-1:0] colour;
  logic            in_block, last_px, wr;
  logic [31:0]     nbx, nby;

  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    case (pat_q)
      2'd0: begin
        if (x_q[3:0] == 4'd0 || y_q[3:0] == 4'd0) begin
          pr = '1;
          pg = '1;
          pb = '1;
        end
      end
      2'd1: begin
        pr = C'(x_q >> 3);
        pg = C'(y_q >> 3);
        pb = pr + pg;
      end
      default: begin
        pr = bgr_q;
        pg = bgg_q;
        pb = bgb_q;
      end
    endcase
    in_block = (x_q >= bx_q) && ({16'd0, x_q} < {16'd0, bx_q} + 32'(BLOCK)) &&
               (y_q >= by_q) && ({16'd0, y_q} < {16'd0, by_q} + 32'(BLOCK));
    colour = {pr, pg, pb};
    if (in_block) colour = {{C{1'b0}}, {C{1'b1}}, {C{1'b0}}};
`ifdef FB_BORDER_EN
    if (x_q == 16'd0 || x_q == 16'(WIDTH - 1) || y_q == 16'd0 || y_q == 16'(HEIGHT - 1))
      colour = '1;
`endif
  end

  // Write strobe is combinational so a stalled cycle never carries a write.
  assign wr      = (state_q == PIXEL) && enable && (pace_q == 16'd0) && !stall;
  assign last_px = (x_q == 16'(WIDTH - 1)) && (y_q == 16'(HEIGHT - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pace_d  = pace_q;
    bx_d    = bx_q;
    by_d    = by_q;
    frame_d = frame_q;
    acnt_d  = acnt_q;
    aidx_d  = aidx_q;
    pat_d   = pat_q;
    bgr_d   = bgr_q;
    bgg_d   = bgg_q;
    bgb_d   = bgb_q;
    nbx     = 32'(bx_q) + 32'(BLOCK_STEP);
    nby     = 32'(by_q) + 32'(BLOCK);
    case (state_q)
      IDLE: if (enable) state_d = SYNC;
      SYNC: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          x_d     = '0;
          y_d     = '0;
          pace_d  = 16'(CYCLES_PER_PIXEL - 1);
          pat_d   = (pattern_mode == 2'd3) ? aidx_q : pattern_mode;
          state_d = PIXEL;
        end
      end
      PIXEL: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (pace_q != 16'd0) begin
          pace_d = pace_q - 16'd1;
        end else if (!stall) begin
          pace_d = 16'(CYCLES_PER_PIXEL - 1);
          if (x_q == 16'(WIDTH - 1)) begin
            x_d = '0;
            y_d = y_q + 16'd1;
          end else begin
            x_d = x_q + 16'd1;
          end
          if (last_px) begin
            state_d = SYNC;
            frame_d = frame_q + 16'd1;
            if (nbx + 32'(BLOCK) > 32'(WIDTH)) begin
              bx_d = '0;
              by_d = (nby + 32'(BLOCK) > 32'(HEIGHT)) ? 16'd0 : nby[15:0];
            end else begin
              bx_d = nbx[15:0];
            end
            if (frame_d[2:0] == 3'd0) begin
              bgr_d = bgr_q + C'(1);
              bgg_d = bgg_q + C'(2);
              bgb_d = bgb_q + C'(3);
            end
            if (acnt_q == 16'(PATTERN_FRAMES - 1)) begin
              acnt_d = '0;
              aidx_d = (aidx_q == 2'd2) ? 2'd0 : aidx_q + 2'd1;
            end else begin
              acnt_d = acnt_q + 16'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      pace_q  <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      frame_q <= '0;
      acnt_q  <= '0;
      aidx_q  <= '0;
      pat_q   <= '0;
      bgr_q   <= '0;
      bgg_q   <= '1;
      bgb_q   <= C'(1) << (C - 1);
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pace_q  <= pace_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      frame_q <= frame_d;
      acnt_q  <= acnt_d;
      aidx_q  <= aidx_d;
      pat_q   <= pat_d;
      bgr_q   <= bgr_d;
      bgg_q   <= bgg_d;
      bgb_q   <= bgb_d;
    end
  end

  assign fb_vsync  = (state_q == SYNC);
  assign fb_we     = wr;
  assign fb_data   = wr ? colour : '0;
  assign frame_cnt = frame_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fb_pattern_gen.sv
// tb/tb_fb_pattern_gen.sv - randomized bench for fb_pattern_gen, two frame widths side by side.
module tb_fb_pattern_gen;

  localparam int CPP = 2;
  localparam int BLK = 2;
  localparam int STEP = 2;
  localparam int PF = 2;
  localparam int CB = 18;
  localparam int HGT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic stall = 1'b0;
  logic [1:0] mode = 2'd0;

  logic vs [2];
  logic we [2];
  logic bsy [2];
  logic [CB-1:0] dat [2];
  logic [15:0] fcnt [2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int idx [2];
  int done [2];
  int mbx [2];
  int mby [2];
  int pat [2];
  int last_ev [2];
  bit stall_seen [2];
  bit p_en [2];
  bit p_busy [2];
  bit p_lastw [2];
  bit disabled [2];

  always #5 clk = ~clk;

  fb_pattern_gen #(.WIDTH(8), .HEIGHT(HGT), .COLOR_BITS(CB), .CYCLES_PER_PIXEL(CPP),
                   .BLOCK(BLK), .BLOCK_STEP(STEP), .PATTERN_FRAMES(PF)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_mode(mode), .stall(stall),
    .fb_vsync(vs[0]), .fb_we(we[0]), .fb_data(dat[0]), .frame_cnt(fcnt[0]), .busy(bsy[0]));

  fb_pattern_gen #(.WIDTH(64), .HEIGHT(HGT), .COLOR_BITS(CB), .CYCLES_PER_PIXEL(CPP),
                   .BLOCK(BLK), .BLOCK_STEP(STEP), .PATTERN_FRAMES(PF)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_mode(mode), .stall(stall),
    .fb_vsync(vs[1]), .fb_we(we[1]), .fb_data(dat[1]), .frame_cnt(fcnt[1]), .busy(bsy[1]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? 8 : 64;
  endfunction

  function automatic logic [CB-1:0] model_pix(input int w, input int x, input int y, input int p,
                                              input int bx, input int by, input int n);
    int r, g, b, kk;
    logic [CB-1:0] v;
    r = 0; g = 0; b = 0;
    kk = n / 8;
    if (p == 0) begin
      if ((x % 16) == 0 || (y % 16) == 0) begin r = 63; g = 63; b = 63; end
    end else if (p == 1) begin
      r = (x / 8) % 64;
      g = (y / 8) % 64;
      b = (r + g) % 64;
    end else begin
      r = kk % 64;
      g = (63 + 2 * kk) % 64;
      b = (32 + 3 * kk) % 64;
    end
    v = {r[5:0], g[5:0], b[5:0]};
    if (x >= bx && x < bx + BLK && y >= by && y < by + BLK) v = {6'd0, 6'h3F, 6'd0};
`ifdef FB_BORDER_EN
    if (x == 0 || x == w - 1 || y == 0 || y == HGT - 1) v = 18'h3FFFF;
`else
    if (w < 0) v = '0;
`endif
    return v;
  endfunction

  // Reference: busy/vsync follow last cycle's enable; each write is the next raster pixel.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      int w;
      w = wid(k);
      if (!rst_n) begin
        idx[k] = 0; done[k] = 0; mbx[k] = 0; mby[k] = 0; pat[k] = 0;
        p_en[k] = 0; p_busy[k] = 0; p_lastw[k] = 0; stall_seen[k] = 0;
        disabled[k] = 0; last_ev[k] = cyc;
      end else begin
        check_eq("busy", 32'(bsy[k]), 32'(p_en[k]));
        check_eq("vsync", 32'(vs[k]), 32'(p_en[k] && (!p_busy[k] || p_lastw[k])));
        check_eq("frame_cnt", 32'(fcnt[k]), 32'(done[k] % 65536));
        p_lastw[k] = 0;
        if (vs[k]) begin
          if (idx[k] != 0) check_eq("partial_frame_without_abort", 32'(disabled[k]), 32'd1);
          idx[k] = 0;
          disabled[k] = 0;
          pat[k] = (mode == 2'd3) ? (done[k] / PF) % 3 : int'(mode);
          last_ev[k] = cyc;
          stall_seen[k] = 0;
        end else if (we[k]) begin
          check_eq("we_cause", 32'({enable, stall}), 32'd2);
          if (!stall_seen[k]) check_eq("write_gap", 32'(cyc - last_ev[k]), 32'(CPP));
          else check_eq("write_gap_min", 32'(cyc - last_ev[k] >= CPP), 32'd1);
          check_eq("pixel", 32'(dat[k]),
                   32'(model_pix(w, idx[k] % w, idx[k] / w, pat[k], mbx[k], mby[k], done[k])));
          idx[k]++;
          last_ev[k] = cyc;
          stall_seen[k] = 0;
          if (idx[k] == w * HGT) begin
            idx[k] = 0;
            done[k]++;
            p_lastw[k] = 1;
            mbx[k] += STEP;
            if (mbx[k] + BLK > w) begin
              mbx[k] = 0;
              mby[k] += BLK;
              if (mby[k] + BLK > HGT) mby[k] = 0;
            end
          end
        end else if (stall) begin
          stall_seen[k] = 1;
        end
        if (!enable && bsy[k]) disabled[k] = 1;
        p_en[k] = enable;
        p_busy[k] = bsy[k];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    enable = 1'b0;
    stall = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    int hold;
    step(3);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_vsync", 32'(vs[k]), 32'd0);
      check_eq("rst_we", 32'(we[k]), 32'd0);
      check_eq("rst_data", 32'(dat[k]), 32'd0);
      check_eq("rst_frame_cnt", 32'(fcnt[k]), 32'd0);
      check_eq("rst_busy", 32'(bsy[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);

    mode = 2'd0;
    enable = 1'b1;
    step(150);
    mode = 2'd1;
    step(300);
    stall = 1'b1;
    step(10);
    stall = 1'b0;
    step(300);
    step(37);
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    step(200);

    do_reset();
    mode = 2'd3;
    enable = 1'b1;
    step(420);

    do_reset();
    mode = 2'd2;
    enable = 1'b1;
    hold = 0;
    for (int i = 0; i < 12000; i++) begin
      stall = ($urandom_range(0, 5) == 0);
      if (hold > 0) begin
        hold--;
        if (hold == 0) enable = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        enable = 1'b0;
        hold = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
      step(1);
    end
    stall = 1'b0;
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
